shk_rr_arbiter: RTL
===================

SHK_RR_ARBITER -- requirements
Module: shk_rr_arbiter

Interface
REQ-001 Parameter NB_REQ, 4: number of shake requesters, legal range 2..4.
REQ-002 Parameter WD_SHK_DATA, 16: shake data width.
REQ-003 Parameter WD_SHK_ADDR, 16: shake address width.
REQ-004 Parameter NB_TIMEOUT, 1024: WAIT-state cycle limit, at least 2.
REQ-005 Parameter WD_ERR_INFO, 4: error info width, fixed at 4.
REQ-006 Port i_sys_clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 Port i_sys_resetn, input, 1: reset, synchronous and active-low.
REQ-008 Ports s_shk_arb_valid/msync, input, NB_REQ: per-requester request pulse and sync flag.
REQ-009 Ports s_shk_arb_mdata/maddr, input, NB_REQ*WD_SHK_DATA / NB_REQ*WD_SHK_ADDR: packed request payloads, requester i in slice i.
REQ-010 Ports s_shk_arb_ready/ssync, output, NB_REQ: per-requester response pulse and returned sync.
REQ-011 Ports s_shk_arb_sdata/saddr, output, WD_SHK_DATA / WD_SHK_ADDR: response payload, shared by all requesters, qualified by s_shk_arb_ready.
REQ-012 Ports m_shk_arb_valid/msync/mdata/maddr, output, 1/1/WD_SHK_DATA/WD_SHK_ADDR: downstream request.
REQ-013 Ports m_shk_arb_ready/ssync/sdata/saddr, input, 1/1/WD_SHK_DATA/WD_SHK_ADDR: downstream response.
REQ-014 Port m_err_arb_info1, output, 4: bit0 timeout (sticky); bit1 overrun (sticky); bits3:2 index of the requester behind the last error.

Function
REQ-015 A valid pulse on requester i with pending[i]=0 shall set pending[i] and latch its msync/mdata/maddr.
REQ-016 A valid pulse on requester i with pending[i]=1 shall be discarded, set err bit1 and load bits3:2 with i.
REQ-017 FSM states shall be IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE with any pending bit set: grant the first pending requester searching from rr_ptr upward with wrap, register the grant index, go to ISSUE.
REQ-019 ISSUE: m_shk_arb_valid=1 for exactly one cycle with the granted latched payload, then WAIT.
REQ-020 m_shk_arb_ready sampled high in ISSUE or WAIT: capture ssync/sdata/saddr, go to RESP.
REQ-021 RESP: pulse s_shk_arb_ready[grant] and ssync[grant] for one cycle with the captured payload; clear pending[grant]; set rr_ptr=(grant+1) mod NB_REQ; go to IDLE.
REQ-022 A new valid on the granted requester during its RESP cycle shall be accepted as a fresh request (pending re-set, not overrun).
REQ-023 Uncontended latency: requester valid at cycle t, m valid at t+2; m ready at cycle u, s ready at u+1.
REQ-024 m_shk_arb_mdata/maddr/msync shall hold the last issued values outside ISSUE; s_shk_arb_ready shall be 0 outside RESP.

Reset
REQ-025 Reset low shall, at the next edge and from any state including mid-transaction, force IDLE, pending=0, rr_ptr=0, grant=0, every output 0, and m_err_arb_info1=0.

Configuration
REQ-026 Macro SHK_ARB_TIMEOUT_EN defined: a WAIT counter shall count from ISSUE onward. NB_TIMEOUT cycles without ready shall force RESP with sdata=0, saddr=0, ssync=0, set err bit0 and load bits3:2 with the grant index.
REQ-027 Macro SHK_ARB_TIMEOUT_EN undefined: WAIT shall persist indefinitely, no counter shall exist, and err bit0 shall be tied to 0.

Structure
REQ-028 Package shk_arb_pkg shall hold the FSM state encoding and the error bit-position constants.
REQ-029 Sub-module shk_rr_pick shall be the combinational round-robin selector (pending vector, rr_ptr in; grant index and any flag out).

Verification
REQ-030 Single request: requester 2 valid, maddr=0x0010, mdata=0x0008; downstream ready 1 cycle after m valid -> m valid at t+2 with those values; s_ready[2] pulse returns sdata/saddr.
REQ-031 Contention: requesters 0,1,3 valid in the same cycle, rr_ptr=0 -> grant order 0,1,3; a second round with rr_ptr=1 -> order 1,3,0.
REQ-032 Overrun: requester 1 valid twice before its response -> err=0b0110 (idx 1, bit1); first payload is issued.
REQ-033 Timeout (macro on, NB_TIMEOUT=16): no downstream ready -> s_ready pulse with sdata=0 and err bit0 set; next pending request is then served normally.
REQ-034 Reset mid-WAIT with 3 requests pending -> all outputs 0 next cycle; no response is ever issued for the pre-reset requests.
REQ-035 Back-to-back: requester 0 re-issues valid in its RESP cycle -> accepted and re-granted, with no overrun flagged.

Source files
------------

// File: rtl/shk_arb_pkg.sv
// Shared FSM encoding, error-field layout and pointer helper for the shake round-robin arbiter.
package shk_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Requester index is always carried in 2 bits (NB_REQ <= 4), matching the error index field.
  localparam int IDX_W       = 2;
  localparam int WD_ERR      = 4;
  localparam int ERR_TMO_BIT = 0;
  localparam int ERR_OVR_BIT = 1;
  localparam int ERR_IDX_LSB = 2;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int nb);
    return (int'(idx) == nb - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/shk_rr_pick.sv
// Combinational round-robin selector: first set pending bit at or above rr_ptr, with wrap.
module shk_rr_pick
  import shk_arb_pkg::*;
#(
  parameter int NB_REQ = 4
) (
  input  logic [NB_REQ-1:0] pending,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              any
);

  always_comb begin : p_pick
    int j;
    logic [IDX_W-1:0] jj;
    j     = 0;
    jj    = '0;
    grant = '0;
    // Walk from farthest to nearest so the nearest pending requester wins.
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NB_REQ) j = j - NB_REQ;
      jj = IDX_W'(j);
      if (pending[jj]) grant = jj;
    end
  end

  assign any = |pending;

endmodule

// File: rtl/shk_rr_arbiter.sv
// Round-robin arbiter funnelling NB_REQ shake requesters onto one downstream shake port.
// Optional downstream timeout enabled with `define SHK_ARB_TIMEOUT_EN.
module shk_rr_arbiter
  import shk_arb_pkg::*;
#(
  parameter int NB_REQ      = 4,
  parameter int WD_SHK_DATA = 16,
  parameter int WD_SHK_ADDR = 16,
  parameter int NB_TIMEOUT  = 1024,
  parameter int WD_ERR_INFO = 4
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_resetn,
  input  logic [NB_REQ-1:0]             s_shk_arb_valid,
  input  logic [NB_REQ-1:0]             s_shk_arb_msync,
  input  logic [NB_REQ*WD_SHK_DATA-1:0] s_shk_arb_mdata,
  input  logic [NB_REQ*WD_SHK_ADDR-1:0] s_shk_arb_maddr,
  output logic [NB_REQ-1:0]             s_shk_arb_ready,
  output logic [NB_REQ-1:0]             s_shk_arb_ssync,
  output logic [WD_SHK_DATA-1:0]        s_shk_arb_sdata,
  output logic [WD_SHK_ADDR-1:0]        s_shk_arb_saddr,
  output logic                          m_shk_arb_valid,
  output logic                          m_shk_arb_msync,
  output logic [WD_SHK_DATA-1:0]        m_shk_arb_mdata,
  output logic [WD_SHK_ADDR-1:0]        m_shk_arb_maddr,
  input  logic                          m_shk_arb_ready,
  input  logic                          m_shk_arb_ssync,
  input  logic [WD_SHK_DATA-1:0]        m_shk_arb_sdata,
  input  logic [WD_SHK_ADDR-1:0]        m_shk_arb_saddr,
  output logic [WD_ERR_INFO-1:0]        m_err_arb_info1
);

  if (NB_REQ < 2 || NB_REQ > 4) begin : g_chk_nb_req
    $error("shk_rr_arbiter: NB_REQ must be in 2..4");
  end
  if (NB_TIMEOUT < 2) begin : g_chk_timeout
    $error("shk_rr_arbiter: NB_TIMEOUT must be at least 2");
  end
  if (WD_ERR_INFO != WD_ERR) begin : g_chk_err_w
    $error("shk_rr_arbiter: WD_ERR_INFO must be 4");
  end

  arb_state_t state, state_nxt;

  logic [NB_REQ-1:0]                  pending;
  logic [NB_REQ-1:0]                  req_msync;
  logic [NB_REQ-1:0][WD_SHK_DATA-1:0] req_mdata;
  logic [NB_REQ-1:0][WD_SHK_ADDR-1:0] req_maddr;
  logic [NB_REQ-1:0]                  accept, overrun, refill;

  logic [IDX_W-1:0]       rr_ptr, grant, pick_idx, ovr_idx;
  logic                   pick_any, busy, tmo_hit;
  logic                   rsp_ssync;
  logic [WD_SHK_DATA-1:0] rsp_sdata;
  logic [WD_SHK_ADDR-1:0] rsp_saddr;
  logic                   err_tmo, err_ovr;
  logic [IDX_W-1:0]       err_idx;

  assign busy = (state == ST_ISSUE) || (state == ST_WAIT);

  // Per-requester capture; the granted requester may re-arm during its own RESP cycle.
  for (genvar i = 0; i < NB_REQ; i++) begin : g_req
    assign refill[i]  = (state == ST_RESP) && (grant == IDX_W'(i));
    assign accept[i]  = s_shk_arb_valid[i] && (!pending[i] || refill[i]);
    assign overrun[i] = s_shk_arb_valid[i] && pending[i] && !refill[i];

    always_ff @(posedge i_sys_clk) begin
      if (!i_sys_resetn) begin
        pending[i]   <= 1'b0;
        req_msync[i] <= 1'b0;
        req_mdata[i] <= '0;
        req_maddr[i] <= '0;
      end else if (accept[i]) begin
        pending[i]   <= 1'b1;
        req_msync[i] <= s_shk_arb_msync[i];
        req_mdata[i] <= s_shk_arb_mdata[i*WD_SHK_DATA +: WD_SHK_DATA];
        req_maddr[i] <= s_shk_arb_maddr[i*WD_SHK_ADDR +: WD_SHK_ADDR];
      end else if (refill[i]) begin
        pending[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    ovr_idx = '0;
    for (int i = 0; i < NB_REQ; i++)
      if (overrun[i]) ovr_idx = IDX_W'(i);
  end

  shk_rr_pick #(.NB_REQ(NB_REQ)) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .grant   (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:           if (pick_any) state_nxt = ST_ISSUE;
      ST_ISSUE, ST_WAIT: state_nxt = (m_shk_arb_ready || tmo_hit) ? ST_RESP : ST_WAIT;
      ST_RESP:           state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_resetn) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      grant           <= '0;
      m_shk_arb_msync <= 1'b0;
      m_shk_arb_mdata <= '0;
      m_shk_arb_maddr <= '0;
      rsp_ssync       <= 1'b0;
      rsp_sdata       <= '0;
      rsp_saddr       <= '0;
      err_ovr         <= 1'b0;
      err_idx         <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_any) begin
        grant           <= pick_idx;
        m_shk_arb_msync <= req_msync[pick_idx];
        m_shk_arb_mdata <= req_mdata[pick_idx];
        m_shk_arb_maddr <= req_maddr[pick_idx];
      end
      if (busy && m_shk_arb_ready) begin
        rsp_ssync <= m_shk_arb_ssync;
        rsp_sdata <= m_shk_arb_sdata;
        rsp_saddr <= m_shk_arb_saddr;
      end else if (tmo_hit) begin
        rsp_ssync <= 1'b0;
        rsp_sdata <= '0;
        rsp_saddr <= '0;
      end
      if (state == ST_RESP) rr_ptr <= rr_next(grant, NB_REQ);
      if (|overrun) begin
        err_ovr <= 1'b1;
        err_idx <= ovr_idx;
      end
      if (tmo_hit) err_idx <= grant;
    end
  end

`ifdef SHK_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(NB_TIMEOUT);
  logic [CNT_W-1:0] tmo_cnt;

  // Counter is zero on entry to ISSUE, so the ISSUE cycle is the first counted cycle.
  assign tmo_hit = busy && !m_shk_arb_ready && (tmo_cnt == CNT_W'(NB_TIMEOUT - 1));

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_resetn) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      if (state == ST_IDLE) tmo_cnt <= '0;
      else if (busy)        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) err_tmo <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  assign m_shk_arb_valid = (state == ST_ISSUE);
  assign s_shk_arb_ready = (state == ST_RESP) ? (NB_REQ'(1) << grant) : '0;
  assign s_shk_arb_ssync = (state == ST_RESP && rsp_ssync) ? (NB_REQ'(1) << grant) : '0;
  assign s_shk_arb_sdata = rsp_sdata;
  assign s_shk_arb_saddr = rsp_saddr;

  always_comb begin
    m_err_arb_info1                         = '0;
    m_err_arb_info1[ERR_TMO_BIT]            = err_tmo;
    m_err_arb_info1[ERR_OVR_BIT]            = err_ovr;
    m_err_arb_info1[ERR_IDX_LSB +: IDX_W]   = err_idx;
  end

endmodule
